iecdrv_sd_arb: RTL and testbench
================================

// Module: iecdrv_sd_arb
// PURPOSE
//  Shares one SD-card block port among NDRIVES IEC drive instances. Each drive's track loader
//  issues whole-track read/write requests. The arbiter grants them one at a time in round-robin
//  order and forwards the selected request to the host SD interface. It routes sd_ack,
//  sd_buff_wr and write data only to the granted drive. Sits between the drives' sd_* ports
//  and the top-level SD host, in the clk_sys domain.
// PARAMETERS
//  NDRIVES   4       number of drive ports, 1..4
//  WDOG_CYC  2**24   max clk_sys cycles from request issue to sd_ack rise (SD_ARB_WDOG_EN only)
// PORTS
//  clk_sys        in   1          system clock; all logic on rising edge
//  reset_n        in   1          asynchronous, active-low reset
//  drv_lba        in   NDRIVES*32 per-drive LBA; drive d owns bits [32d+31:32d]
//  drv_blk_cnt    in   NDRIVES*6  per-drive block count minus 1
//  drv_rd         in   NDRIVES    per-drive read request; level, held until its drv_ack rises
//  drv_wr         in   NDRIVES    per-drive write request; level, held until its drv_ack rises
//  drv_ack        out  NDRIVES    sd_ack, forwarded to the granted drive only
//  drv_buff_wr    out  NDRIVES    sd_buff_wr, forwarded to the granted drive only
//  drv_buff_din   in   NDRIVES*8  per-drive write data for the host
//  sd_lba         out  32         latched LBA of the current grant
//  sd_blk_cnt     out  6          latched block count of the current grant
//  sd_rd, sd_wr   out  1          host request strobes (level)
//  sd_ack         in   1          host transfer-active flag
//  sd_buff_wr     in   1          host write strobe into the granted drive's buffer
//  sd_buff_din    out  8          drv_buff_din of the granted drive; combinational mux
//  busy           out  1          high in any state except IDLE
//  err            out  1          sticky watchdog error (SD_ARB_WDOG_EN); otherwise tied 0
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; rr_ptr = NDRIVES-1, so drive 0 has first priority.
//  Request pending for drive d: drv_rd[d] | drv_wr[d]. If both are high, the write wins.
//  State machine:
//   IDLE -> REQ: taken at the first edge with any request pending.
//    - grant = first pending drive searching rr_ptr+1, rr_ptr+2, ... modulo NDRIVES.
//    - At that same edge: latch sd_lba, sd_blk_cnt and dir; assert sd_rd or sd_wr; rr_ptr <= grant.
//    - So a request present before edge k gives sd_rd/sd_wr high from edge k (1-cycle latency).
//   REQ -> XFER: on sd_ack = 1. sd_rd and sd_wr drop at that edge.
//   XFER -> GAP: on sd_ack = 0.
//   GAP -> IDLE: unconditional, after 1 cycle. This lets the drive drop its request before
//    arbitration runs again.
//  drv_ack[grant] = sd_ack in REQ and XFER; all other drv_ack bits stay 0.
//  drv_buff_wr[grant] = sd_buff_wr in XFER only; sd_buff_wr outside XFER is ignored.
//  Latched lba, blk_cnt and grant stay stable from REQ through GAP. Request-line changes after
//   the grant are ignored until IDLE.
//  A granted drive that drops its request in REQ does not cancel the host transfer. It completes
//   and the data is discarded by that drive.
//  Simultaneous requests: strict round-robin. A drive re-requesting right after service goes
//   behind every other pending drive.
//  NDRIVES = 1: rr search degenerates to always granting drive 0.
//  reset_n low in any state: immediate return to IDLE and all outputs 0, including
//   mid-transfer. The host is expected to be reset on the same reset_n.
// CONFIGURATION
//  SD_ARB_WDOG_EN defined:
//   - A counter clears on entry to REQ and increments each cycle in REQ.
//   - When it reaches WDOG_CYC: drop sd_rd/sd_wr, go to GAP and set err. Also pulse
//     drv_ack[grant] for 1 cycle so the drive's loader leaves its wait state.
//   - err clears only on reset_n.
//  SD_ARB_WDOG_EN undefined: no counter logic; REQ waits indefinitely; err = 0.
// STRUCTURE
//  Package iecdrv_sd_pkg:
//   - typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_XFER, ARB_GAP} arb_state_t
//   - localparams IECDRV_MAX_DRIVES = 4, SD_LBA_W = 32, SD_BLKCNT_W = 6
//  Sub-module iecdrv_rr_pick: combinational round-robin picker.
//   - inputs: req vector, rr_ptr
//   - outputs: grant index, valid
// TESTING
//  T1 Single read: drv_rd[2] = 1, lba = 0x1234 -> next edge sd_rd = 1, sd_lba = 0x1234.
//     Host raises ack -> drv_ack = 4'b0100, sd_rd = 0. 3 sd_buff_wr pulses reach drv_buff_wr[2] only.
//  T2 Contention: drv_rd = 4'b1111 held, host acks each request in 10 cycles ->
//     grant order 0, 1, 2, 3, 0; at least 1 GAP cycle between sd_rd pulses.
//  T3 rd & wr both high on drive 1 -> sd_wr = 1, sd_rd = 0.
//     sd_buff_din follows drv_buff_din[15:8] while sd_buff_wr is toggled.
//  T4 Reset mid-XFER: reset_n low 2 cycles with sd_ack = 1 -> busy = 0 and all outputs 0
//     immediately; after release, a fresh drv_rd[3] is granted with rr_ptr starting from drive 0.
//  T5 Stray strobes: sd_buff_wr pulsed in IDLE and GAP -> every drv_buff_wr bit stays 0.
//  T6 (SD_ARB_WDOG_EN, WDOG_CYC = 100) Host never acks drv_wr[0] ->
//     sd_wr = 0 and err = 1 after 100 cycles; 1-cycle drv_ack[0] pulse; next request still served.

Source files
------------

// File: rtl/iecdrv_sd_arb_pkg.sv
// -----------------------------------------------------------------------------
// iecdrv_sd_pkg
// Shared types and sizes for the SD-card block-port arbiter that sits between
// the IEC drive track loaders and the top-level SD host.
//   arb_state_t       : arbiter FSM encoding (also exposed on dbg_state)
//   IECDRV_MAX_DRIVES : upper bound on drive ports
//   SD_LBA_W          : width of an SD block address
//   SD_BLKCNT_W       : width of a block count (count minus 1)
//   DRV_IDX_W         : width of a drive index, sized for IECDRV_MAX_DRIVES
// -----------------------------------------------------------------------------
package iecdrv_sd_pkg;

   localparam int IECDRV_MAX_DRIVES = 4;
   localparam int SD_LBA_W          = 32;
   localparam int SD_BLKCNT_W       = 6;
   localparam int DRV_IDX_W         = 2;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_REQ,
      ARB_XFER,
      ARB_GAP
   } arb_state_t;

endpackage

// File: rtl/iecdrv_sd_arb_if.sv
// -----------------------------------------------------------------------------
// iecdrv_sd_arb_if
// Host-side SD block port shared by all drives.
//   sd_lba, sd_blk_cnt : address and block count of the current request
//   sd_rd, sd_wr       : request strobes, level
//   sd_ack             : host transfer-active flag
//   sd_buff_wr         : host write strobe into the requesting buffer
//   sd_buff_din        : write data from the requester to the host
// Modports: master = arbiter side, slave = SD host side.
//
// Handshake: sd_rd/sd_wr act as "valid" and hold, together with sd_lba and
// sd_blk_cnt, until the host raises sd_ack ("ready"/accept). sd_ack then stays
// high for the whole transfer; sd_buff_wr strobes are meaningful only while
// sd_ack is high. The request is complete when sd_ack falls.
// -----------------------------------------------------------------------------
interface iecdrv_sd_arb_if import iecdrv_sd_pkg::*; ();

   logic [SD_LBA_W-1:0]    sd_lba;
   logic [SD_BLKCNT_W-1:0] sd_blk_cnt;
   logic                   sd_rd;
   logic                   sd_wr;
   logic                   sd_ack;
   logic                   sd_buff_wr;
   logic [7:0]             sd_buff_din;

   modport master (
      output sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
      input  sd_ack, sd_buff_wr
   );

   modport slave (
      input  sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
      output sd_ack, sd_buff_wr
   );

endinterface

// File: rtl/iecdrv_sd_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// iecdrv_rr_pick
// Combinational round-robin picker. Searches rr_ptr+1, rr_ptr+2, ... modulo N
// and returns the first set request bit.
//   req    in  N          pending request vector
//   rr_ptr in  DRV_IDX_W  index of the most recently granted drive
//   grant  out DRV_IDX_W  selected drive (0 when nothing is pending)
//   valid  out 1          at least one request pending
// -----------------------------------------------------------------------------
module iecdrv_rr_pick import iecdrv_sd_pkg::*; #(
   parameter int N = 4
) (
   input  logic [N-1:0]           req,
   input  logic [DRV_IDX_W-1:0]   rr_ptr,
   output logic [DRV_IDX_W-1:0]   grant,
   output logic                   valid
);

   // Padding to the maximum width lets a DRV_IDX_W index select any bit
   // regardless of N.
   logic [IECDRV_MAX_DRIVES-1:0] req_pad;
   assign req_pad = IECDRV_MAX_DRIVES'(req);

   always_comb begin
      logic [DRV_IDX_W-1:0] idx;
      idx   = '0;
      grant = '0;
      valid = 1'b0;
      for (int i = 1; i <= N; i++) begin
         idx = DRV_IDX_W'((int'(rr_ptr) + i) % N);
         if (!valid && req_pad[idx]) begin
            valid = 1'b1;
            grant = idx;
         end
      end
   end

endmodule

// File: rtl/iecdrv_sd_arb.sv
// -----------------------------------------------------------------------------
// iecdrv_sd_arb
// Shares one SD-card block port among NDRIVES IEC drive track loaders. Whole-
// track requests are granted one at a time in round-robin order; sd_ack and
// sd_buff_wr are routed back only to the granted drive.
//   clk_sys, reset_n : clock and asynchronous active-low reset
//   drv_lba          : per-drive LBA, drive d at [32d+31:32d]
//   drv_blk_cnt      : per-drive block count minus 1, drive d at [6d+5:6d]
//   drv_rd, drv_wr   : per-drive request levels (write wins if both high)
//   drv_ack          : sd_ack forwarded to the granted drive
//   drv_buff_wr      : sd_buff_wr forwarded to the granted drive during XFER
//   drv_buff_din     : per-drive write data, drive d at [8d+7:8d]
//   sd               : host port (iecdrv_sd_arb_if.master)
//   busy             : arbiter not IDLE
//   err              : sticky request-timeout flag (0 without the watchdog)
//   dbg_state        : current FSM state
// Optional feature macro: SD_ARB_WDOG_EN adds a request watchdog of WDOG_CYC
// cycles; a timeout drops the request, pulses drv_ack and sets err.
// -----------------------------------------------------------------------------
module iecdrv_sd_arb import iecdrv_sd_pkg::*; #(
   parameter int NDRIVES  = 4
`ifdef SD_ARB_WDOG_EN
  ,parameter int WDOG_CYC = 2**24
`endif
) (
   input  logic                    clk_sys,
   input  logic                    reset_n,
   input  logic [NDRIVES*32-1:0]   drv_lba,
   input  logic [NDRIVES*6-1:0]    drv_blk_cnt,
   input  logic [NDRIVES-1:0]      drv_rd,
   input  logic [NDRIVES-1:0]      drv_wr,
   output logic [NDRIVES-1:0]      drv_ack,
   output logic [NDRIVES-1:0]      drv_buff_wr,
   input  logic [NDRIVES*8-1:0]    drv_buff_din,
   iecdrv_sd_arb_if.master         sd,
   output logic                    busy,
   output logic                    err,
   output arb_state_t              dbg_state
);

   arb_state_t             state;
   logic [DRV_IDX_W-1:0]   rr_ptr;
   logic [DRV_IDX_W-1:0]   grant;
   logic [DRV_IDX_W-1:0]   pick;
   logic                   pick_valid;
   logic [SD_LBA_W-1:0]    pick_lba;
   logic [SD_BLKCNT_W-1:0] pick_blk;
   logic                   pick_wr;
   logic [7:0]             gnt_din;
   logic [SD_LBA_W-1:0]    lba_q;
   logic [SD_BLKCNT_W-1:0] blk_q;
   logic                   rd_q;
   logic                   wr_q;
   logic                   wdog_ack;   // one-cycle drv_ack pulse after a timeout

`ifdef SD_ARB_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYC + 1);
   logic [WDOG_W-1:0] wdog_cnt;
   logic              err_q;
   assign err = err_q;
`else
   assign err      = 1'b0;
   assign wdog_ack = 1'b0;
`endif

   iecdrv_rr_pick #(.N(NDRIVES)) u_pick (
      .req    (drv_rd | drv_wr),
      .rr_ptr (rr_ptr),
      .grant  (pick),
      .valid  (pick_valid)
   );

   // Per-drive field selection for the candidate (pick) and the active grant.
   always_comb begin
      pick_lba = '0;
      pick_blk = '0;
      pick_wr  = 1'b0;
      gnt_din  = '0;
      for (int d = 0; d < NDRIVES; d++) begin
         if (pick == DRV_IDX_W'(d)) begin
            pick_lba = drv_lba[32*d +: 32];
            pick_blk = drv_blk_cnt[6*d +: 6];
            pick_wr  = drv_wr[d];
         end
         if (grant == DRV_IDX_W'(d)) begin
            gnt_din = drv_buff_din[8*d +: 8];
         end
      end
   end

   always_comb begin
      drv_ack     = '0;
      drv_buff_wr = '0;
      for (int d = 0; d < NDRIVES; d++) begin
         if (grant == DRV_IDX_W'(d)) begin
            drv_ack[d]     = (((state == ARB_REQ) || (state == ARB_XFER)) && sd.sd_ack) || wdog_ack;
            drv_buff_wr[d] = (state == ARB_XFER) && sd.sd_buff_wr;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ARB_IDLE;
         rr_ptr   <= DRV_IDX_W'(NDRIVES - 1);
         grant    <= '0;
         lba_q    <= '0;
         blk_q    <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
`ifdef SD_ARB_WDOG_EN
         wdog_cnt <= '0;
         wdog_ack <= 1'b0;
         err_q    <= 1'b0;
`endif
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_valid) begin
                  state  <= ARB_REQ;
                  grant  <= pick;
                  rr_ptr <= pick;
                  lba_q  <= pick_lba;
                  blk_q  <= pick_blk;
                  wr_q   <= pick_wr;
                  rd_q   <= ~pick_wr;
`ifdef SD_ARB_WDOG_EN
                  wdog_cnt <= '0;
`endif
               end
            end
            ARB_REQ: begin
               if (sd.sd_ack) begin
                  state <= ARB_XFER;
                  rd_q  <= 1'b0;
                  wr_q  <= 1'b0;
               end
`ifdef SD_ARB_WDOG_EN
               // Leaves after WDOG_CYC cycles in REQ without an ack.
               else if (wdog_cnt == WDOG_W'(WDOG_CYC - 1)) begin
                  state    <= ARB_GAP;
                  rd_q     <= 1'b0;
                  wr_q     <= 1'b0;
                  err_q    <= 1'b1;
                  wdog_ack <= 1'b1;
               end else begin
                  wdog_cnt <= wdog_cnt + WDOG_W'(1);
               end
`endif
            end
            ARB_XFER: begin
               if (!sd.sd_ack) state <= ARB_GAP;
            end
            ARB_GAP: begin
               // One idle cycle gives the served drive time to drop its request.
               state <= ARB_IDLE;
`ifdef SD_ARB_WDOG_EN
               wdog_ack <= 1'b0;
`endif
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign sd.sd_lba      = lba_q;
   assign sd.sd_blk_cnt  = blk_q;
   assign sd.sd_rd       = rd_q;
   assign sd.sd_wr       = wr_q;
   assign busy           = (state != ARB_IDLE);
   // Held at 0 in IDLE so the host sees no stale data between grants.
   assign sd.sd_buff_din = busy ? gnt_din : 8'h00;
   assign dbg_state      = state;

endmodule

// File: tb/tb_iecdrv_sd_arb.sv
// -----------------------------------------------------------------------------
// tb_iecdrv_sd_arb
// Bench for iecdrv_sd_arb with NDRIVES = 4. A bench-side SD host answers
// requests; expected grants ({drive, wr, rd, blk_cnt, lba}) are queued when a
// drive raises its request and compared when the host sees sd_rd/sd_wr.
// With SD_ARB_WDOG_EN defined the DUT is built with WDOG_CYC = 100 and the
// timeout path is exercised as well.
// -----------------------------------------------------------------------------
module tb_iecdrv_sd_arb;
  import iecdrv_sd_pkg::*;

  localparam int ND = 4;
  localparam int W  = 42;

  // clock / reset
  logic clk_sys = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk_sys = ~clk_sys;

  logic [ND*32-1:0] drv_lba;
  logic [ND*6-1:0]  drv_blk_cnt;
  logic [ND-1:0]    drv_rd;
  logic [ND-1:0]    drv_wr;
  logic [ND-1:0]    drv_ack;
  logic [ND-1:0]    drv_buff_wr;
  logic [ND*8-1:0]  drv_buff_din;
  logic             busy;
  logic             err;
  arb_state_t       dbg_state;

  iecdrv_sd_arb_if sd ();

  iecdrv_sd_arb #(
    .NDRIVES (ND)
`ifdef SD_ARB_WDOG_EN
   ,.WDOG_CYC(100)
`endif
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .drv_lba      (drv_lba),
    .drv_blk_cnt  (drv_blk_cnt),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_ack      (drv_ack),
    .drv_buff_wr  (drv_buff_wr),
    .drv_buff_din (drv_buff_din),
    .sd           (sd),
    .busy         (busy),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Expected grant record built from the stimulus of drive d; write wins.
  task automatic push_exp(input int d);
    logic [W-1:0] e;
    e = {2'(d), drv_wr[d], drv_rd[d] & ~drv_wr[d], drv_blk_cnt[6*d +: 6], drv_lba[32*d +: 32]};
    exp_q.push_back(e);
  endtask

  task automatic set_drive(input int d, input logic [31:0] lba, input logic [5:0] blk,
                           input logic rd, input logic wr);
    drv_lba[32*d +: 32]  = lba;
    drv_blk_cnt[6*d +: 6] = blk;
    drv_rd[d] = rd;
    drv_wr[d] = wr;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Host model: serve one request. drop: 0 keep requests, 1 granted drive
  // drops on ack, 2 every drive drops on ack.
  task automatic serve(input int ack_dly, input int n_buff, input int drop);
    int t;
    int d;
    logic [W-1:0] e;
    t = 0;
    while (!(sd.sd_rd || sd.sd_wr) && t < 100) begin
      tick();
      t++;
    end
    check("req_seen", 64'(sd.sd_rd | sd.sd_wr), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    d = int'(e[41:40]);
    check("sd_req", 64'({sd.sd_wr, sd.sd_rd, sd.sd_blk_cnt, sd.sd_lba}), 64'(e[39:0]));
    check("busy_req", 64'(busy), 64'd1);
    repeat (ack_dly) tick();
    sd.sd_ack = 1'b1;
    #1;
    check("drv_ack", 64'(drv_ack), 64'(4'b0001 << d));
    if (drop == 1) begin
      drv_rd[d] = 1'b0;
      drv_wr[d] = 1'b0;
    end else if (drop == 2) begin
      drv_rd = '0;
      drv_wr = '0;
    end
    tick();
    check("req_drop", 64'({sd.sd_rd, sd.sd_wr}), 64'd0);
    check("state_xfer", 64'(dbg_state), 64'(ARB_XFER));
    for (int i = 0; i < n_buff; i++) begin
      drv_buff_din[8*d +: 8] = 8'($urandom_range(0, 255));
      sd.sd_buff_wr = 1'b1;
      #1;
      check("buff_wr", 64'(drv_buff_wr), 64'(4'b0001 << d));
      check("buff_din", 64'(sd.sd_buff_din), 64'(drv_buff_din[8*d +: 8]));
      tick();
      sd.sd_buff_wr = 1'b0;
      tick();
    end
    sd.sd_ack = 1'b0;
    tick();
    check("state_gap", 64'(dbg_state), 64'(ARB_GAP));
    check("gap_no_req", 64'({sd.sd_rd, sd.sd_wr}), 64'd0);
    sd.sd_buff_wr = 1'b1;
    #1;
    check("gap_buff_wr", 64'(drv_buff_wr), 64'd0);
    check("gap_ack", 64'(drv_ack), 64'd0);
    sd.sd_buff_wr = 1'b0;
    tick();
    check("state_idle", 64'(dbg_state), 64'(ARB_IDLE));
  endtask

  // global time bound
  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    drv_lba       = '0;
    drv_blk_cnt   = '0;
    drv_rd        = '0;
    drv_wr        = '0;
    drv_buff_din  = '0;
    sd.sd_ack     = 1'b0;
    sd.sd_buff_wr = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    // reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req", 64'({sd.sd_rd, sd.sd_wr}), 64'd0);
    check("rst_lba", 64'(sd.sd_lba), 64'd0);
    check("rst_blk", 64'(sd.sd_blk_cnt), 64'd0);
    check("rst_drv_ack", 64'(drv_ack), 64'd0);
    check("rst_din", 64'(sd.sd_buff_din), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ARB_IDLE));
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // stray strobe in IDLE
    sd.sd_buff_wr = 1'b1;
    #1;
    check("idle_buff_wr", 64'(drv_buff_wr), 64'd0);
    sd.sd_buff_wr = 1'b0;
    tick();

    // T1 single read on drive 2, one-cycle latency
    set_drive(2, 32'h0000_1234, 6'd7, 1'b1, 1'b0);
    push_exp(2);
    tick();
    check("t1_latency", 64'(sd.sd_rd), 64'd1);
    check("t1_lba", 64'(sd.sd_lba), 64'h1234);
    serve(2, 3, 1);

    // T2 contention after reset: order 0,1,2,3,0
    do_reset();
    for (int d = 0; d < ND; d++) set_drive(d, 32'hA000_0000 + 32'(d), 6'(d + 1), 1'b1, 1'b0);
    push_exp(0);
    push_exp(1);
    push_exp(2);
    push_exp(3);
    push_exp(0);
    for (int k = 0; k < 4; k++) serve(10, 1, 0);
    serve(10, 1, 2);

    // T3 read and write both high on drive 1: write wins
    set_drive(1, 32'h0000_55AA, 6'd35, 1'b1, 1'b1);
    push_exp(1);
    tick();
    check("t3_wr", 64'({sd.sd_wr, sd.sd_rd}), 64'b10);
    serve(1, 4, 1);

    // T4 reset mid-transfer, then round-robin restarts at drive 0
    set_drive(2, 32'h0BAD_0002, 6'd3, 1'b1, 1'b0);
    tick();
    check("t4_req", 64'(sd.sd_rd), 64'd1);
    sd.sd_ack = 1'b1;
    tick();
    check("t4_xfer", 64'(dbg_state), 64'(ARB_XFER));
    reset_n = 1'b0;
    #1;
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_req0", 64'({sd.sd_rd, sd.sd_wr}), 64'd0);
    check("t4_lba0", 64'(sd.sd_lba), 64'd0);
    check("t4_blk0", 64'(sd.sd_blk_cnt), 64'd0);
    check("t4_ack0", 64'(drv_ack), 64'd0);
    check("t4_din0", 64'(sd.sd_buff_din), 64'd0);
    drv_rd[2] = 1'b0;
    tick();
    tick();
    sd.sd_ack = 1'b0;
    reset_n   = 1'b1;
    tick();
    set_drive(3, 32'h3333_0003, 6'd9, 1'b1, 1'b0);
    set_drive(0, 32'h0000_0F00, 6'd1, 1'b1, 1'b0);
    push_exp(0);
    push_exp(3);
    serve(0, 1, 1);
    serve(0, 1, 1);

`ifdef SD_ARB_WDOG_EN
    // T6 host never acks a write on drive 0
    begin
      int n;
      set_drive(0, 32'h0000_D0D0, 6'd2, 1'b0, 1'b1);
      n = 0;
      while (!sd.sd_wr && n < 10) begin
        tick();
        n++;
      end
      check("t6_wr_seen", 64'(sd.sd_wr), 64'd1);
      n = 0;
      while (sd.sd_wr && n < 300) begin
        tick();
        n++;
      end
      check("t6_cycles", 64'(n), 64'd100);
      check("t6_err", 64'(err), 64'd1);
      check("t6_ack_pulse", 64'(drv_ack), 64'b0001);
      check("t6_state", 64'(dbg_state), 64'(ARB_GAP));
      drv_wr[0] = 1'b0;
      tick();
      check("t6_ack_end", 64'(drv_ack), 64'd0);
      set_drive(1, 32'h0000_1111, 6'd4, 1'b1, 1'b0);
      push_exp(1);
      serve(2, 1, 1);
      check("t6_err_sticky", 64'(err), 64'd1);
    end
`endif

    check("exp_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
